// File: rtl/snn_spike_fire_unit_if.sv
// Bundles the psum input stream and the spike-record output stream of the fire unit.
// A transfer on either stream happens at a rising clk edge where valid && ready are both 1.
interface snn_spike_fire_unit_if #(
    parameter int PSUM_WIDTH = 8,
    parameter int NUM_NEURON = 3,
    parameter int NUM_TS     = 2
);
    localparam int IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
    localparam int TS_W  = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;

    logic                         psum_valid;
    logic                         psum_ready;
    logic signed [PSUM_WIDTH-1:0] psum_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_spike;
    logic [IDX_W-1:0]             out_idx;
    logic [TS_W-1:0]              out_ts;
    logic                         out_last;

    modport master (
        output psum_valid, psum_data, out_ready,
        input  psum_ready, out_valid, out_spike, out_idx, out_ts, out_last
    );

    modport slave (
        input  psum_valid, psum_data, out_ready,
        output psum_ready, out_valid, out_spike, out_idx, out_ts, out_last
    );
endinterface

// File: rtl/snn_spike_fire_unit.sv
// Integrate-and-fire output stage: sums NUM_ROWS psums per neuron per timestep into a
// saturating membrane potential and emits one spike record per neuron per timestep.
module snn_spike_fire_unit #(
    parameter int PSUM_WIDTH = 8,
    parameter int POT_WIDTH  = 12,
    parameter int NUM_ROWS   = 3,
    parameter int NUM_NEURON = 3,
    parameter int NUM_TS     = 2,
    parameter int THRESH     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic [1:0]            dbg_state_o,
    snn_spike_fire_unit_if.slave  bus
);
    localparam int IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
    localparam int TS_W  = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
    localparam int CNT_W = $clog2(NUM_ROWS + 1);
    localparam int EXT_W = POT_WIDTH - PSUM_WIDTH;

    localparam logic signed [POT_WIDTH-1:0] POT_MIN  = {1'b1, {(POT_WIDTH-1){1'b0}}};
    localparam logic signed [POT_WIDTH-1:0] POT_MAX  = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] THRESH_P = THRESH[POT_WIDTH-1:0];
    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(NUM_ROWS - 1);
    localparam logic [IDX_W-1:0]            IDX_LAST = IDX_W'(NUM_NEURON - 1);
    localparam logic [TS_W-1:0]             TS_LAST  = TS_W'(NUM_TS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC    = 2'd1,
        S_UPDATE = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic signed [POT_WIDTH-1:0]  row_sum_q, row_sum_d;
    logic [CNT_W-1:0]             row_cnt_q, row_cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [TS_W-1:0]              ts_q, ts_d;
    logic signed [POT_WIDTH-1:0]  pot_q [NUM_NEURON];
    logic signed [POT_WIDTH-1:0]  pot_d [NUM_NEURON];
    logic                         spike_q, spike_d;
    logic                         done_q, done_d;

    logic signed [POT_WIDTH-1:0]  psum_ext;
    logic signed [POT_WIDTH-1:0]  upd_v;
    logic                         is_last;

    // Signed add clamped to the potential range instead of wrapping.
    function automatic logic signed [POT_WIDTH-1:0] sat_add(
        input logic signed [POT_WIDTH-1:0] a,
        input logic signed [POT_WIDTH-1:0] b
    );
        logic [POT_WIDTH:0] s;
        s = {a[POT_WIDTH-1], a} + {b[POT_WIDTH-1], b};
        if (s[POT_WIDTH] != s[POT_WIDTH-1]) begin
            return s[POT_WIDTH] ? POT_MIN : POT_MAX;
        end
        return s[POT_WIDTH-1:0];
    endfunction

    assign psum_ext = {{EXT_W{bus.psum_data[PSUM_WIDTH-1]}}, bus.psum_data};
    assign is_last  = (idx_q == IDX_LAST) && (ts_q == TS_LAST);

    assign bus.psum_ready = (state_q == S_ACC);
    assign bus.out_valid  = (state_q == S_OUT);
    assign bus.out_spike  = spike_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_ts     = ts_q;
    assign bus.out_last   = (state_q == S_OUT) && is_last;
    assign done           = done_q;
    assign dbg_state_o    = state_q;

    always_comb begin
        state_d   = state_q;
        row_sum_d = row_sum_q;
        row_cnt_d = row_cnt_q;
        idx_d     = idx_q;
        ts_d      = ts_q;
        spike_d   = spike_q;
        done_d    = 1'b0;
        pot_d     = pot_q;
        upd_v     = sat_add(pot_q[idx_q], row_sum_q);

        case (state_q)
            S_IDLE: begin
                // A start landing in the done cycle belongs to the finished run, so drop it.
                if (start && !done_q) begin
                    for (int i = 0; i < NUM_NEURON; i++) pot_d[i] = '0;
                    row_sum_d = '0;
                    row_cnt_d = '0;
                    idx_d     = '0;
                    ts_d      = '0;
                    spike_d   = 1'b0;
                    state_d   = S_ACC;
                end
            end
            S_ACC: begin
                if (bus.psum_valid) begin
                    row_sum_d = sat_add(row_sum_q, psum_ext);
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == CNT_LAST) state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (upd_v >= THRESH_P) begin
                    spike_d       = 1'b1;
                    pot_d[idx_q]  = '0;
                end else begin
                    spike_d       = 1'b0;
                    pot_d[idx_q]  = upd_v;
                end
                row_sum_d = '0;
                row_cnt_d = '0;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            ts_d  = ts_q + 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                        state_d = S_ACC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_sum_q <= '0;
            row_cnt_q <= '0;
            idx_q     <= '0;
            ts_q      <= '0;
            spike_q   <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_NEURON; i++) pot_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            row_sum_q <= row_sum_d;
            row_cnt_q <= row_cnt_d;
            idx_q     <= idx_d;
            ts_q      <= ts_d;
            spike_q   <= spike_d;
            done_q    <= done_d;
            pot_q     <= pot_d;
        end
    end
endmodule

// File: tb/tb_snn_spike_fire_unit.sv
// Self-checking bench for snn_spike_fire_unit: a default instance (POT_WIDTH=12, THRESH=64)
// and a saturation instance (POT_WIDTH=10, THRESH=511) share one driver, selected by sel.
module tb_snn_spike_fire_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic psum_valid = 1'b0;
    logic signed [7:0] psum_data = '0;
    logic out_ready = 1'b0;

    logic done_a, done_b;
    logic [1:0] dbg_a, dbg_b;

    always #5 clk = ~clk;

    snn_spike_fire_unit_if #(.PSUM_WIDTH(8), .NUM_NEURON(3), .NUM_TS(2)) if_a ();
    snn_spike_fire_unit_if #(.PSUM_WIDTH(8), .NUM_NEURON(3), .NUM_TS(2)) if_b ();

    assign if_a.psum_valid = psum_valid & ~sel;
    assign if_a.psum_data  = psum_data;
    assign if_a.out_ready  = out_ready & ~sel;
    assign if_b.psum_valid = psum_valid & sel;
    assign if_b.psum_data  = psum_data;
    assign if_b.out_ready  = out_ready & sel;

    snn_spike_fire_unit u_a (
        .clk(clk), .reset(reset), .start(start_a), .done(done_a),
        .dbg_state_o(dbg_a), .bus(if_a.slave)
    );

    snn_spike_fire_unit #(.POT_WIDTH(10), .THRESH(511)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .done(done_b),
        .dbg_state_o(dbg_b), .bus(if_b.slave)
    );

    wire       psum_ready = sel ? if_b.psum_ready : if_a.psum_ready;
    wire       out_valid  = sel ? if_b.out_valid  : if_a.out_valid;
    wire       out_spike  = sel ? if_b.out_spike  : if_a.out_spike;
    wire [1:0] out_idx    = sel ? if_b.out_idx    : if_a.out_idx;
    wire       out_ts     = sel ? if_b.out_ts[0]  : if_a.out_ts[0];
    wire       out_last   = sel ? if_b.out_last   : if_a.out_last;
    wire       done       = sel ? done_b : done_a;
    wire [1:0] dbg_state  = sel ? dbg_b : dbg_a;

    typedef struct {
        bit sel;
        bit new_run;
        int p0, p1, p2;
        bit spike;
        int idx;
        int ts;
        bit last;
        int hold;
        int pot;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pot_peek(input bit s, input int i);
        if (s) return int'(u_b.pot_q[i]);
        return int'(u_a.pot_q[i]);
    endfunction

    task automatic pulse_start();
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        check("ready_after_start", psum_ready, 1);
    endtask

    task automatic send_psum(input int v);
        int n = 0;
        psum_valid = 1'b1;
        psum_data  = 8'(v);
        while (!psum_ready && n < 50) begin
            tick();
            n++;
        end
        if (!psum_ready) fail_now("psum_wait");
        tick();
        psum_valid = 1'b0;
    endtask

    task automatic get_record(input int hold);
        logic [4:0] got, exp;
        int n = 0;
        check("update_no_valid", out_valid, 0);
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            fail_now("out_wait");
            return;
        end
        check("out_latency", n, 1);
        got = {out_spike, out_idx, out_ts, out_last};
        if (exp_q.size() == 0) begin
            fail_now("exp_q_empty");
            return;
        end
        exp = exp_q.pop_front();
        check("record", got, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_fields", {out_valid, out_spike, out_idx, out_ts, out_last}, {1'b1, got});
            check("hold_ready_low", psum_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (exp[0]) begin
            check("done_pulse", done, 1);
            check("idle_after_last", dbg_state, 0);
            if (sel) start_b = 1'b1;
            else     start_a = 1'b1;
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
            check("done_single", done, 0);
            check("start_on_done_ignored", psum_ready, 0);
        end else begin
            check("ready_after_out", psum_ready, 1);
            check("done_low", done, 0);
        end
    endtask

    function automatic void add(input bit s, input bit nr, input int p0, input int p1,
                                input int p2, input bit sp, input int ix, input int t,
                                input bit l, input int hold, input int pot);
        vec_t v;
        v.sel = s; v.new_run = nr; v.p0 = p0; v.p1 = p1; v.p2 = p2;
        v.spike = sp; v.idx = ix; v.ts = t; v.last = l; v.hold = hold; v.pot = pot;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default instance: integrate/fire with a held first record and an exact-threshold fire.
        add(0, 1,  20, 30, 10, 0, 0, 0, 0, 5,  60);
        add(0, 0,   0,  0,  0, 0, 1, 0, 0, 0,   0);
        add(0, 0,  64,  0,  0, 1, 2, 0, 0, 0,   0);
        add(0, 0,   2,  1,  1, 1, 0, 1, 0, 0,   0);
        add(0, 0,  -5, -5, -5, 0, 1, 1, 0, 0, -15);
        add(0, 0,  63,  0,  0, 0, 2, 1, 1, 0,  63);
        for (int t = 0; t < 2; t++)
            for (int n = 0; n < 3; n++)
                add(0, t == 0 && n == 0, 25, 25, 25, 1, n, t, t == 1 && n == 2,
                    $urandom_range(0, 3), 0);
        for (int t = 0; t < 2; t++)
            for (int n = 0; n < 3; n++)
                add(1, t == 0 && n == 0, 127, 127, 127, t == 1, n, t, t == 1 && n == 2,
                    0, (t == 0) ? 381 : 0);
        for (int t = 0; t < 2; t++)
            for (int n = 0; n < 3; n++)
                add(1, t == 0 && n == 0, -128, -128, -128, 0, n, t, t == 1 && n == 2,
                    0, (t == 0) ? -384 : -512);

        // Reset held for two cycles with psum_valid raised.
        reset = 1'b1;
        psum_valid = 1'b1;
        tick();
        tick();
        check("rst_psum_ready", psum_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
        check("rst_out_fields", {out_spike, out_idx, out_ts, out_last}, 0);
        check("rst_pot0", pot_peek(0, 0), 0);
        reset = 1'b0;
        psum_valid = 1'b0;
        tick();
        check("idle_no_ready", psum_ready, 0);

        foreach (vecs[k]) begin
            sel = vecs[k].sel;
            if (vecs[k].new_run) pulse_start();
            send_psum(vecs[k].p0);
            send_psum(vecs[k].p1);
            send_psum(vecs[k].p2);
            exp_q.push_back({vecs[k].spike, 2'(vecs[k].idx), 1'(vecs[k].ts), vecs[k].last});
            get_record(vecs[k].hold);
            check("pot", pot_peek(vecs[k].sel, vecs[k].idx), vecs[k].pot);
        end

        // Mid-run reset after two psums of neuron 1, then a fresh run must start from pot=0.
        sel = 1'b0;
        pulse_start();
        send_psum(40); send_psum(10); send_psum(10);
        exp_q.push_back(5'b00000);
        get_record(0);
        send_psum(5);
        send_psum(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ready", psum_ready, 0);
        check("midrst_state", dbg_state, 0);
        check("midrst_pot0", pot_peek(0, 0), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                seen += int'(out_valid) + int'(done);
            end
            check("midrst_no_record", seen, 0);
        end
        pulse_start();
        send_psum(10); send_psum(10); send_psum(10);
        exp_q.push_back(5'b00000);
        get_record(0);
        check("pot_after_restart", pot_peek(0, 0), 30);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
